// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Covers load-use bubbles, EX-resolved branch flushes and data-memory
// wait-state freezes; keeps saturating stall/flush performance counters
// and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Raddr1_D,
   input  logic [4:0]       Raddr2_D,
   input  logic             use_rs1_D,
   input  logic             use_rs2_D,
   input  logic [4:0]       Waddr_E,
   input  logic             MemRead_E,
   input  logic             branch_taken_E,
   input  logic             dmem_req_M,
   input  logic             dmem_ready_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_W,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [15:0] WAIT_MAX  = 16'(TIMEOUT);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] wait_cnt;
   logic        mem_miss;
   logic        freeze;
   logic        load_use;

   // Hazard detection: memory miss, whole-pipe freeze and load-use dependence.
   always_comb begin
      mem_miss = dmem_req_M & ~dmem_ready_M;
      freeze   = (state_q == MEM_WAIT) | mem_miss;
      // Waddr_E != 0 also guarantees that reads of x0 never match.
      load_use = MemRead_E && (Waddr_E != '0) &&
                 ((use_rs1_D && (Raddr1_D == Waddr_E)) ||
                  (use_rs2_D && (Raddr2_D == Waddr_E)));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Next-state logic: enter MEM_WAIT on a miss, leave when memory is ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (mem_miss)     state_d = MEM_WAIT;
         MEM_WAIT: if (dmem_ready_M) state_d = RUN;
         default:                    state_d = RUN;
      endcase
   end

   // Output logic: freeze > branch flush > load-use bubble; all quiet in reset.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_W = 1'b0;
      if (!rst) begin
         if (freeze) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
         end else if (branch_taken_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
         end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   // Wait-state counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (state_q == MEM_WAIT) begin
         if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
         if (state_d == RUN)             wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX)  wait_cnt <= wait_cnt + 16'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Saturating performance counters for stall cycles and branch flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_F && (stall_count != '1)) stall_count <= stall_count + 1'b1;
         if (flush_D && (flush_count != '1)) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned TIMEOUT = 4;

   // Expected output patterns {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W}
   localparam logic [6:0] O_Z  = 7'b0000000;
   localparam logic [6:0] O_FR = 7'b1111001;
   localparam logic [6:0] O_LU = 7'b1100010;
   localparam logic [6:0] O_BR = 7'b0000110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [4:0]       Raddr1_D, Raddr2_D, Waddr_E;
   logic             use_rs1_D, use_rs2_D, MemRead_E, branch_taken_E;
   logic             dmem_req_M, dmem_ready_M;
   logic             stall_F, stall_D, stall_E, stall_M;
   logic             flush_D, flush_E, flush_W, mem_timeout;
   logic [CNT_W-1:0] stall_count, flush_count;
   logic [6:0]       outs_act;

   assign outs_act = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .Raddr1_D(Raddr1_D), .Raddr2_D(Raddr2_D),
      .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .Waddr_E(Waddr_E), .MemRead_E(MemRead_E),
      .branch_taken_E(branch_taken_E),
      .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
      .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
      .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
      .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   typedef struct {
      int               id;
      logic [6:0]       outs;
      logic             mto;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   step_id  = 0;

   task automatic set_in(input logic r, input logic mr, input logic [4:0] wa,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic br, input logic req, input logic rdy);
      rst            = r;
      MemRead_E      = mr;
      Waddr_E        = wa;
      Raddr1_D       = r1;
      use_rs1_D      = u1;
      Raddr2_D       = r2;
      use_rs2_D      = u2;
      branch_taken_E = br;
      dmem_req_M     = req;
      dmem_ready_M   = rdy;
   endtask

   task automatic idle();
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
   endtask

   // Queue the expectation for the current cycle, then advance one clock.
   task automatic step(input logic [6:0] eo, input logic em,
                       input logic [CNT_W-1:0] esc, input logic [CNT_W-1:0] efc);
      exp_t e;
      e.id   = step_id;
      e.outs = eo;
      e.mto  = em;
      e.sc   = esc;
      e.fc   = efc;
      sb.push_back(e);
      step_id++;
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin : mon
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (outs_act !== e.outs) begin
            failures++;
            $display("FAIL step%0d outs got %b want %b", e.id, outs_act, e.outs);
         end
         checks++;
         if (mem_timeout !== e.mto) begin
            failures++;
            $display("FAIL step%0d mem_timeout got %b want %b", e.id, mem_timeout, e.mto);
         end
         checks++;
         if (stall_count !== e.sc) begin
            failures++;
            $display("FAIL step%0d stall_count got %0d want %0d", e.id, stall_count, e.sc);
         end
         checks++;
         if (flush_count !== e.fc) begin
            failures++;
            $display("FAIL step%0d flush_count got %0d want %0d", e.id, flush_count, e.fc);
         end
      end
   end

   initial begin
      set_in(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      // Reset forces outputs low even with hazards present
      set_in(1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 1, 0);  step(O_Z, 0, 0, 0);
      idle();                                          step(O_Z, 0, 0, 0);

      // Load-use via rs2, then load moves to MEM
      set_in(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0);  step(O_LU, 0, 0, 0);
      idle();                                          step(O_Z, 0, 1, 0);

      // x0 load and unused operand never stall
      set_in(0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0);  step(O_Z, 0, 1, 0);
      set_in(0, 1, 5'd7, 5'd7, 0, 5'd3, 1, 0, 0, 0);  step(O_Z, 0, 1, 0);
      // Load-use via rs1; same match without a load does nothing
      set_in(0, 1, 5'd7, 5'd7, 1, 5'd3, 1, 0, 0, 0);  step(O_LU, 0, 1, 0);
      set_in(0, 0, 5'd7, 5'd7, 1, 5'd3, 1, 0, 0, 0);  step(O_Z, 0, 2, 0);

      // Branch flush, then branch beating a load-use
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);  step(O_BR, 0, 2, 0);
      idle();                                          step(O_Z, 0, 2, 1);
      set_in(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0);  step(O_BR, 0, 2, 1);
      idle();                                          step(O_Z, 0, 2, 2);

      // Memory wait: 3 miss cycles then ready, branch held throughout
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);  step(O_FR, 0, 2, 2);
                                                       step(O_FR, 0, 3, 2);
                                                       step(O_FR, 0, 4, 2);
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);  step(O_FR, 0, 5, 2);
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);  step(O_BR, 0, 6, 2);
      idle();                                          step(O_Z, 0, 6, 3);
      // Access that hits immediately does not freeze
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);  step(O_Z, 0, 6, 3);

      // Timeout: ready low for 10 cycles; stall_count saturates at 15
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);  step(O_FR, 0, 6, 3);
                                                       step(O_FR, 0, 7, 3);
                                                       step(O_FR, 0, 8, 3);
                                                       step(O_FR, 0, 9, 3);
                                                       step(O_FR, 0, 10, 3);
                                                       step(O_FR, 1, 11, 3);
                                                       step(O_FR, 1, 12, 3);
                                                       step(O_FR, 1, 13, 3);
                                                       step(O_FR, 1, 14, 3);
                                                       step(O_FR, 1, 15, 3);
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);  step(O_FR, 1, 15, 3);
      idle();                                          step(O_Z, 1, 15, 3);
                                                       step(O_Z, 1, 15, 3);
      // Reset clears sticky timeout and counters
      set_in(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);  step(O_Z, 1, 15, 3);
      idle();                                          step(O_Z, 0, 0, 0);

      // Reset in the middle of MEM_WAIT
      set_in(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);  step(O_FR, 0, 0, 0);
                                                       step(O_FR, 0, 1, 0);
      set_in(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);  step(O_Z, 0, 2, 0);
      idle();                                          step(O_Z, 0, 0, 0);
                                                       step(O_Z, 0, 0, 0);

      for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending got %0d want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It runs alongside the operand-forwarding logic and covers the hazards forwarding cannot resolve:
- load-use dependences (one-bubble stall),
- taken branches/jumps resolved in EX (flush of IF/ID and ID/EX),
- data-memory wait states (full freeze, with timeout detection).

It drives the enable/flush pins of every pipeline register and keeps hazard performance counters.

Parameters:
CNT_W, 32, width of the stall_count and flush_count performance counters (saturating)
TIMEOUT, 64, MEM_WAIT cycles after which mem_timeout is raised; valid range 2..65535

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous active-high reset
Raddr1_D  in  5  rs1 of instruction in ID
Raddr2_D  in  5  rs2 of instruction in ID
use_rs1_D  in  1  ID instruction actually reads rs1
use_rs2_D  in  1  ID instruction actually reads rs2
Waddr_E  in  5  rd of instruction in EX
MemRead_E  in  1  EX instruction is a load
branch_taken_E  in  1  EX resolved a taken branch/jump (redirect PC)
dmem_req_M  in  1  MEM stage is issuing a data-memory access
dmem_ready_M  in  1  data memory completes the access this cycle
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID register
stall_E  out  1  hold ID/EX register
stall_M  out  1  hold EX/MEM register
flush_D  out  1  clear IF/ID to NOP
flush_E  out  1  clear ID/EX to NOP (bubble)
flush_W  out  1  clear MEM/WB to NOP
mem_timeout  out  1  sticky error: MEM_WAIT lasted at least TIMEOUT cycles
stall_count  out  CNT_W  cycles with stall_F=1
flush_count  out  CNT_W  branch flush events

Behaviour:
- State machine has two states:
  - RUN: normal operation.
  - MEM_WAIT: entered when dmem_req_M=1 and dmem_ready_M=0.
- RUN to MEM_WAIT:
  - Outputs are combinational from state plus inputs.
  - Freeze applies in the same cycle the miss is seen: stall_F/D/E/M=1 and flush_W=1 (bubble into WB), other flushes 0.
- In MEM_WAIT:
  - Freeze outputs persist.
  - wait_cnt (16 bit) increments each cycle, saturating at TIMEOUT.
  - On the cycle dmem_ready_M=1, outputs are still frozen and the next state is RUN.
  - In the following RUN cycle the pipeline advances normally.
- Priority in RUN (highest first):
  1. Memory freeze. Branch and load-use are masked; EX is frozen, so they are re-evaluated once the pipeline advances.
  2. Branch flush: flush_D=1, flush_E=1, no stalls. flush_count increments once per cycle with branch_taken_E=1.
  3. Load-use stall. Condition: MemRead_E && Waddr_E!=0 && ((use_rs1_D && Raddr1_D==Waddr_E) || (use_rs2_D && Raddr2_D==Waddr_E)). Response: stall_F=1, stall_D=1, flush_E=1 for exactly one cycle. The next cycle the load is in MEM, so the condition clears naturally and forwarding covers the dependence.
  4. Otherwise all outputs are 0.
- Branch and load-use in the same cycle: the branch wins and load-use is ignored, because the dependent ID instruction is flushed.
- Rules for x0: reads of x0 never stall; a load with Waddr_E=0 never stalls.
- mem_timeout:
  - Set when wait_cnt reaches TIMEOUT-1 while still in MEM_WAIT, i.e. on the TIMEOUT-th MEM_WAIT cycle.
  - Sticky until rst; it does not alter the freeze.
  - wait_cnt clears on return to RUN.
- stall_count increments on every cycle with stall_F=1, including MEM_WAIT freeze cycles and the RUN cycle of freeze detection. Both counters saturate at all-ones.
- Reset:
  - With rst=1 at a clock edge: state goes to RUN; wait_cnt, mem_timeout and both counters go to 0.
  - While rst=1, all stall/flush outputs are forced to 0, regardless of the other inputs.
  - Reset in the middle of MEM_WAIT abandons the wait; the next cycle is RUN.

Test Plan:
- Load-use: MemRead_E=1, Waddr_E=5, Raddr2_D=5, use_rs2_D=1 -> one cycle of stall_F=stall_D=flush_E=1. The next cycle, with the load moved to MEM, all outputs are 0. stall_count=1.
- x0 and unused operands: Waddr_E=0 with a matching Raddr1_D=0 -> no stall. Waddr_E=7, Raddr1_D=7, use_rs1_D=0 -> no stall.
- Branch: branch_taken_E=1 for 1 cycle -> flush_D=flush_E=1 for 1 cycle, stall_F=0, flush_count=1. With a load-use condition also true in that cycle -> same response, no stall.
- Memory wait: dmem_req_M=1 with dmem_ready_M=0 for 3 cycles, then ready=1 -> freeze held for 4 cycles, then RUN. stall_count=4, mem_timeout=0. With branch_taken_E=1 throughout, flush_D/flush_E assert only on the first post-freeze cycle.
- Timeout: TIMEOUT=4, dmem_ready_M held 0 for 10 cycles -> mem_timeout rises on the 4th MEM_WAIT cycle and stays 1 after ready. rst=1 -> mem_timeout=0 and counters 0.
- Reset mid-wait: assert rst during MEM_WAIT -> outputs 0 while rst=1. After release with dmem_req_M=0, the state is RUN and outputs stay 0.
